// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator request controller: FSM state encoding
// and direction codes presented on the drc input.
package elevator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DELAY = 2'b01,
    ST_OPEN  = 2'b10,
    ST_FAULT = 2'b11
  } state_t;

  localparam logic [1:0] DRC_IDLE = 2'b00;
  localparam logic [1:0] DRC_UP   = 2'b01;
  localparam logic [1:0] DRC_DN   = 2'b10;

  // The unused code 11 behaves exactly like idle.
  function automatic logic [1:0] drc_norm(input logic [1:0] d);
    return (d == 2'b11) ? DRC_IDLE : d;
  endfunction

endpackage

// File: rtl/req_latch.sv
// One car-button channel: latches a press until serviced, and cancels the
// request once the button has been held for CANCEL_TICKS consecutive samples.
module req_latch #(
  parameter int CANCEL_TICKS = 1000
) (
  input  logic clk_1KHz,
  input  logic rst_n,
  input  logic press,
  input  logic clr,
  input  logic flush,
  input  logic flush_val,
  output logic req_n
);

  localparam int CW = $clog2(CANCEL_TICKS + 1);

  logic [CW-1:0] hold_cnt;
  logic [CW-1:0] hold_nxt;
  logic          req_nxt;
  logic          cancel;

  // Saturating hold counter keeps the request cleared until the button is released.
  always_comb begin
    hold_nxt = '0;
    cancel   = 1'b0;
    req_nxt  = ~req_n;
    if (flush) begin
      req_nxt = flush_val;
    end else begin
      if (press) begin
        hold_nxt = (hold_cnt == CW'(CANCEL_TICKS)) ? hold_cnt : hold_cnt + CW'(1);
      end
      cancel = press && (hold_nxt == CW'(CANCEL_TICKS));
      if (cancel || clr) begin
        req_nxt = 1'b0;
      end else if (press) begin
        req_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_1KHz or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
      req_n    <= 1'b1;
    end else begin
      hold_cnt <= hold_nxt;
      req_n    <= ~req_nxt;
    end
  end

endmodule

// File: rtl/elevator_req_ctrl.sv
// Elevator request controller: latches hall and car calls, decides when the
// car stops at c_floor, and sequences the door through delay/open/fault.
module elevator_req_ctrl
  import elevator_pkg::*;
#(
  parameter int N_FLOORS     = 4,
  parameter int OPEN_DLY     = 1000,
  parameter int OPEN_HOLD    = 5000,
  parameter int CANCEL_TICKS = 1000,
  localparam int FW          = $clog2(N_FLOORS)
) (
  input  logic                clk_1KHz,
  input  logic                rst_n,
  input  logic [N_FLOORS-1:0] hall_up_n,
  input  logic [N_FLOORS-1:0] hall_dn_n,
  input  logic [N_FLOORS-1:0] car_n,
  input  logic [FW-1:0]       c_floor,
  input  logic [1:0]          drc,
  input  logic                lock,
  input  logic                err,
  input  logic                full,
  output logic [N_FLOORS-1:0] up_req_n,
  output logic [N_FLOORS-1:0] dn_req_n,
  output logic [N_FLOORS-1:0] car_req_n,
  output logic                arrival_n,
  output logic                door_n
);

  localparam int TMAX = (OPEN_DLY > OPEN_HOLD) ? OPEN_DLY : OPEN_HOLD;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [N_FLOORS-1:0] UP_MASK = {1'b0, {(N_FLOORS-1){1'b1}}};
  localparam logic [N_FLOORS-1:0] DN_MASK = {{(N_FLOORS-1){1'b1}}, 1'b0};

  state_t              state, state_nxt;
  logic [TW-1:0]       tmr, tmr_nxt;
  logic                arrival_nxt, door_nxt;
  logic                take, any_hit;
  logic [1:0]          drc_e;
  logic [N_FLOORS-1:0] at_floor, up_ok, dn_ok;
  logic [N_FLOORS-1:0] up_hit, dn_hit, car_hit;
  logic [N_FLOORS-1:0] up_nxt, dn_nxt;

  assign drc_e = drc_norm(drc);

  // Hall calls honour travel direction; a full car only stops for car calls.
  always_comb begin
    at_floor = '0;
    up_ok    = '0;
    dn_ok    = '0;
    for (int f = 0; f < N_FLOORS; f++) begin
      at_floor[f] = (int'(c_floor) == f);
      up_ok[f]    = !full && ((drc_e != DRC_DN) || (f == 0));
      dn_ok[f]    = !full && ((drc_e != DRC_UP) || (f == N_FLOORS - 1));
    end
  end

  assign up_hit  = at_floor & up_ok & ~up_req_n;
  assign dn_hit  = at_floor & dn_ok & ~dn_req_n;
  assign car_hit = at_floor & ~car_req_n;
  assign any_hit = |{up_hit, dn_hit, car_hit};

  always_comb begin
    state_nxt   = state;
    tmr_nxt     = tmr;
    arrival_nxt = arrival_n;
    door_nxt    = door_n;
    take        = 1'b0;
    case (state)
      ST_IDLE: begin
        tmr_nxt = '0;
        if ((lock || (drc_e == DRC_IDLE)) && any_hit) begin
          take        = 1'b1;
          state_nxt   = ST_DELAY;
          arrival_nxt = 1'b0;
        end
      end
      ST_DELAY: begin
        if (any_hit || (tmr == TW'(OPEN_DLY - 1))) begin
          take      = any_hit;
          state_nxt = ST_OPEN;
          tmr_nxt   = '0;
          door_nxt  = 1'b0;
        end else begin
          tmr_nxt = tmr + TW'(1);
        end
      end
      ST_OPEN: begin
        if (any_hit) begin
          take    = 1'b1;
          tmr_nxt = '0;
        end else if (tmr == TW'(OPEN_HOLD - 1)) begin
          state_nxt   = ST_IDLE;
          tmr_nxt     = '0;
          door_nxt    = 1'b1;
          arrival_nxt = 1'b1;
        end else begin
          tmr_nxt = tmr + TW'(1);
        end
      end
      default: begin
        state_nxt   = ST_IDLE;
        tmr_nxt     = '0;
        door_nxt    = 1'b1;
        arrival_nxt = 1'b1;
      end
    endcase
    // A fault parks the car with the door open only at the ground floor.
    if (err) begin
      take        = 1'b0;
      state_nxt   = ST_FAULT;
      tmr_nxt     = '0;
      door_nxt    = (c_floor == '0) ? 1'b0 : 1'b1;
      arrival_nxt = door_nxt;
    end
  end

  // Service clears are applied after new presses so that service wins a collision.
  always_comb begin
    up_nxt = '0;
    dn_nxt = '0;
    if (!err) begin
      up_nxt = ((~up_req_n) | (~hall_up_n & UP_MASK)) & ~(take ? up_hit : '0);
      dn_nxt = ((~dn_req_n) | (~hall_dn_n & DN_MASK)) & ~(take ? dn_hit : '0);
    end
  end

  always_ff @(posedge clk_1KHz or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      tmr       <= '0;
      arrival_n <= 1'b1;
      door_n    <= 1'b1;
      up_req_n  <= '1;
      dn_req_n  <= '1;
    end else begin
      state     <= state_nxt;
      tmr       <= tmr_nxt;
      arrival_n <= arrival_nxt;
      door_n    <= door_nxt;
      up_req_n  <= ~up_nxt;
      dn_req_n  <= ~dn_nxt;
    end
  end

  for (genvar g = 0; g < N_FLOORS; g++) begin : g_car
    req_latch #(
      .CANCEL_TICKS(CANCEL_TICKS)
    ) u_car (
      .clk_1KHz (clk_1KHz),
      .rst_n    (rst_n),
      .press    (~car_n[g]),
      .clr      (take & car_hit[g]),
      .flush    (err),
      .flush_val(g == 0),
      .req_n    (car_req_n[g])
    );
  end

endmodule

// File: tb/tb_elevator_req_ctrl.sv
// Directed bench for elevator_req_ctrl: a 4-floor instance with default timing
// and an 8-floor instance with short timing for the reset-during-stop case.
module tb_elevator_req_ctrl;
  import elevator_pkg::*;

  localparam int S_UP = 0, S_DN = 1, S_CAR = 2, S_ARR = 3, S_DOOR = 4;
  localparam int S_UP8 = 5, S_DN8 = 6, S_CAR8 = 7, S_ARR8 = 8, S_DOOR8 = 9, S_ST8 = 10;

  typedef struct {
    string       tag;
    int          sig;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  logic       clk_1KHz = 1'b0;
  logic       rst_n    = 1'b1;
  logic [3:0] hall_up_n = '1, hall_dn_n = '1, car_n = '1;
  logic [1:0] c_floor = 2'd3;
  logic [1:0] drc = 2'b01;
  logic       lock = 1'b0, err = 1'b0, full = 1'b0;
  logic [3:0] up_req_n, dn_req_n, car_req_n;
  logic       arrival_n, door_n;

  logic       rst8_n = 1'b1;
  logic [7:0] hall_up8_n = '1, hall_dn8_n = '1, car8_n = '1;
  logic [2:0] c8 = 3'd0;
  logic [1:0] drc8 = 2'b01;
  logic       lock8 = 1'b0;
  logic [7:0] up8_n, dn8_n, car8_req_n;
  logic       arr8_n, door8_n;

  always #5 clk_1KHz = ~clk_1KHz;

  elevator_req_ctrl #(
    .N_FLOORS(4), .OPEN_DLY(1000), .OPEN_HOLD(5000), .CANCEL_TICKS(1000)
  ) dut (
    .clk_1KHz(clk_1KHz), .rst_n(rst_n),
    .hall_up_n(hall_up_n), .hall_dn_n(hall_dn_n), .car_n(car_n),
    .c_floor(c_floor), .drc(drc), .lock(lock), .err(err), .full(full),
    .up_req_n(up_req_n), .dn_req_n(dn_req_n), .car_req_n(car_req_n),
    .arrival_n(arrival_n), .door_n(door_n)
  );

  elevator_req_ctrl #(
    .N_FLOORS(8), .OPEN_DLY(4), .OPEN_HOLD(6), .CANCEL_TICKS(8)
  ) dut8 (
    .clk_1KHz(clk_1KHz), .rst_n(rst8_n),
    .hall_up_n(hall_up8_n), .hall_dn_n(hall_dn8_n), .car_n(car8_n),
    .c_floor(c8), .drc(drc8), .lock(lock8), .err(1'b0), .full(1'b0),
    .up_req_n(up8_n), .dn_req_n(dn8_n), .car_req_n(car8_req_n),
    .arrival_n(arr8_n), .door_n(door8_n)
  );

  function automatic logic [15:0] observe(input int sig);
    case (sig)
      S_UP:    return {12'b0, up_req_n};
      S_DN:    return {12'b0, dn_req_n};
      S_CAR:   return {12'b0, car_req_n};
      S_ARR:   return {15'b0, arrival_n};
      S_DOOR:  return {15'b0, door_n};
      S_UP8:   return {8'b0, up8_n};
      S_DN8:   return {8'b0, dn8_n};
      S_CAR8:  return {8'b0, car8_req_n};
      S_ARR8:  return {15'b0, arr8_n};
      S_DOOR8: return {15'b0, door8_n};
      default: return {14'b0, dut8.state};
    endcase
  endfunction

  function automatic void pushExpect(input string tag, input int sig, input logic [15:0] exp);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.exp = exp;
    sb.push_back(e);
  endfunction

  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk_1KHz);
      #1;
    end
  endtask

  task automatic checkOutput();
    exp_t        e;
    logic [15:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sig);
      total++;
      assert (obs === e.exp) else begin
        bad++;
        $error("[TB] FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Asynchronous reset, checked before any clock edge.
    #1 rst_n = 1'b0; rst8_n = 1'b0;
    #1;
    pushExpect("rst_up", S_UP, 16'hF);
    pushExpect("rst_dn", S_DN, 16'hF);
    pushExpect("rst_car", S_CAR, 16'hF);
    pushExpect("rst_arr", S_ARR, 16'h1);
    pushExpect("rst_door", S_DOOR, 16'h1);
    pushExpect("rst8_state", S_ST8, 16'(ST_IDLE));
    checkOutput();
    applyStimulus(2);
    rst_n = 1'b1; rst8_n = 1'b1;
    applyStimulus(2);

    // Car call to floor 2 served on a lock strobe.
    c_floor = 2'd1; car_n[2] = 1'b0;
    applyStimulus(1);
    pushExpect("car2_latch", S_CAR, 16'b1011);
    checkOutput();
    applyStimulus(2);
    car_n[2] = 1'b1;
    applyStimulus(1);
    pushExpect("car2_hold", S_CAR, 16'b1011);
    checkOutput();
    c_floor = 2'd2; lock = 1'b1;
    applyStimulus(1);
    lock = 1'b0;
    pushExpect("car2_clr", S_CAR, 16'hF);
    pushExpect("stop_arr", S_ARR, 16'h0);
    pushExpect("stop_door_shut", S_DOOR, 16'h1);
    checkOutput();
    applyStimulus(999);
    pushExpect("dly_999", S_DOOR, 16'h1);
    checkOutput();
    applyStimulus(1);
    pushExpect("dly_1000", S_DOOR, 16'h0);
    checkOutput();
    applyStimulus(4999);
    pushExpect("hold_4999", S_DOOR, 16'h0);
    checkOutput();
    applyStimulus(1);
    pushExpect("hold_end_door", S_DOOR, 16'h1);
    pushExpect("hold_end_arr", S_ARR, 16'h1);
    checkOutput();

    // Hold-to-cancel on car button 1.
    car_n[1] = 1'b0;
    applyStimulus(1);
    pushExpect("cancel_t1", S_CAR, 16'b1101);
    checkOutput();
    applyStimulus(998);
    pushExpect("cancel_t999", S_CAR, 16'b1101);
    checkOutput();
    applyStimulus(1);
    pushExpect("cancel_t1000", S_CAR, 16'hF);
    checkOutput();
    applyStimulus(200);
    pushExpect("cancel_t1200", S_CAR, 16'hF);
    checkOutput();
    car_n[1] = 1'b1;
    applyStimulus(2);
    pushExpect("cancel_release", S_CAR, 16'hF);
    checkOutput();

    // Full car skips the hall call at floor 1 and stops for the car call at 3.
    full = 1'b1; hall_up_n[1] = 1'b0; car_n[3] = 1'b0;
    applyStimulus(1);
    hall_up_n[1] = 1'b1; car_n[3] = 1'b1;
    pushExpect("full_up_latch", S_UP, 16'b1101);
    pushExpect("full_car_latch", S_CAR, 16'b0111);
    checkOutput();
    c_floor = 2'd1; drc = 2'b01; lock = 1'b1;
    applyStimulus(1);
    lock = 1'b0;
    pushExpect("full_skip_arr", S_ARR, 16'h1);
    pushExpect("full_skip_up", S_UP, 16'b1101);
    checkOutput();
    c_floor = 2'd3; lock = 1'b1;
    applyStimulus(1);
    lock = 1'b0;
    pushExpect("full_stop_arr", S_ARR, 16'h0);
    pushExpect("full_stop_car", S_CAR, 16'hF);
    pushExpect("full_stop_up", S_UP, 16'b1101);
    checkOutput();
    applyStimulus(6000);
    pushExpect("full_done_door", S_DOOR, 16'h1);
    pushExpect("full_done_arr", S_ARR, 16'h1);
    checkOutput();
    full = 1'b0;

    // Hall-down call at the open floor extends the door hold.
    c_floor = 2'd2; drc = 2'b00; car_n[2] = 1'b0;
    applyStimulus(1);
    car_n[2] = 1'b1;
    pushExpect("ext_car_latch", S_CAR, 16'b1011);
    checkOutput();
    applyStimulus(1);
    pushExpect("ext_stop_car", S_CAR, 16'hF);
    pushExpect("ext_stop_arr", S_ARR, 16'h0);
    checkOutput();
    applyStimulus(1000);
    pushExpect("ext_open", S_DOOR, 16'h0);
    checkOutput();
    applyStimulus(4000);
    hall_dn_n[2] = 1'b0;
    applyStimulus(1);
    pushExpect("ext_dn_latch", S_DN, 16'b1011);
    checkOutput();
    applyStimulus(1);
    hall_dn_n[2] = 1'b1;
    pushExpect("ext_service_wins", S_DN, 16'hF);
    pushExpect("ext_door_open", S_DOOR, 16'h0);
    checkOutput();
    applyStimulus(4999);
    pushExpect("ext_hold_4999", S_DOOR, 16'h0);
    pushExpect("ext_up_kept", S_UP, 16'b1101);
    checkOutput();
    applyStimulus(1);
    pushExpect("ext_close_door", S_DOOR, 16'h1);
    pushExpect("ext_close_arr", S_ARR, 16'h1);
    checkOutput();

    // Fault handling away from and at the ground floor.
    c_floor = 2'd3; drc = 2'b01; car_n[1] = 1'b0;
    applyStimulus(1);
    car_n[1] = 1'b1;
    pushExpect("pre_fault_car", S_CAR, 16'b1101);
    checkOutput();
    err = 1'b1;
    applyStimulus(1);
    pushExpect("fault_up", S_UP, 16'hF);
    pushExpect("fault_dn", S_DN, 16'hF);
    pushExpect("fault_car", S_CAR, 16'b1110);
    pushExpect("fault_door_f3", S_DOOR, 16'h1);
    pushExpect("fault_arr_f3", S_ARR, 16'h1);
    checkOutput();
    hall_up_n[0] = 1'b0; car_n[2] = 1'b0;
    applyStimulus(1);
    hall_up_n[0] = 1'b1; car_n[2] = 1'b1;
    pushExpect("fault_ign_up", S_UP, 16'hF);
    pushExpect("fault_ign_car", S_CAR, 16'b1110);
    checkOutput();
    c_floor = 2'd0;
    applyStimulus(1);
    pushExpect("fault_door_f0", S_DOOR, 16'h0);
    pushExpect("fault_arr_f0", S_ARR, 16'h0);
    checkOutput();
    applyStimulus(10);
    pushExpect("fault_door_held", S_DOOR, 16'h0);
    checkOutput();
    err = 1'b0;
    applyStimulus(1);
    pushExpect("unfault_door", S_DOOR, 16'h1);
    pushExpect("unfault_arr", S_ARR, 16'h1);
    pushExpect("unfault_car", S_CAR, 16'b1110);
    checkOutput();
    drc = 2'b00;
    applyStimulus(1);
    pushExpect("f0_stop_arr", S_ARR, 16'h0);
    pushExpect("f0_stop_car", S_CAR, 16'hF);
    checkOutput();
    applyStimulus(6000);
    pushExpect("f0_done_door", S_DOOR, 16'h1);
    checkOutput();

    // Eight floors: masked edge buttons, a down stop, then reset while open.
    car8_n[7] = 1'b0; hall_dn8_n[5] = 1'b0; hall_up8_n[7] = 1'b0; hall_dn8_n[0] = 1'b0;
    applyStimulus(1);
    car8_n = '1; hall_dn8_n = '1; hall_up8_n = '1;
    pushExpect("n8_car_latch", S_CAR8, 16'h7F);
    pushExpect("n8_dn_latch", S_DN8, 16'hDF);
    pushExpect("n8_up_masked", S_UP8, 16'hFF);
    checkOutput();
    c8 = 3'd5; drc8 = 2'b10; lock8 = 1'b1;
    applyStimulus(1);
    lock8 = 1'b0;
    pushExpect("n8_stop_arr", S_ARR8, 16'h0);
    pushExpect("n8_stop_dn", S_DN8, 16'hFF);
    checkOutput();
    applyStimulus(6);
    pushExpect("n8_open", S_DOOR8, 16'h0);
    pushExpect("n8_open_state", S_ST8, 16'(ST_OPEN));
    checkOutput();
    #2 rst8_n = 1'b0;
    #1;
    pushExpect("n8_rst_up", S_UP8, 16'hFF);
    pushExpect("n8_rst_dn", S_DN8, 16'hFF);
    pushExpect("n8_rst_car", S_CAR8, 16'hFF);
    pushExpect("n8_rst_arr", S_ARR8, 16'h1);
    pushExpect("n8_rst_door", S_DOOR8, 16'h1);
    pushExpect("n8_rst_state", S_ST8, 16'(ST_IDLE));
    checkOutput();
    applyStimulus(1);
    rst8_n = 1'b1;
    applyStimulus(2);
    pushExpect("n8_after_car", S_CAR8, 16'hFF);
    pushExpect("n8_after_door", S_DOOR8, 16'h1);
    checkOutput();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
